arbitro_memoria: RTL and testbench
==================================

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of cycles to wait for mem_ready before aborting; 0 disables the timeout.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports if_req in 1, if_addr in 32, if_gnt out 1, if_valid out 1 and if_rdata out 32, forming the instruction-fetch requester (read-only).
REQ-005 SHALL have ports dados_req in 1, dados_we in 1, dados_addr in 32, dados_wdata in 32, dados_gnt out 1, dados_valid out 1 and dados_rdata out 32, forming the load/store requester.
- dados_req = c_memoria != 00.
- dados_we = c_memoria == 10.
REQ-006 SHALL have ports uart_req in 1, uart_we in 1, uart_addr in 32, uart_wdata in 32, uart_gnt out 1 and uart_valid out 1, forming the UART program loader.
REQ-007 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32 and mem_ready in 1, forming the single shared memory port.
REQ-008 SHALL have ports stall out 1 (pipeline freeze) and erro out 1 (sticky timeout flag).

Function
REQ-009 SHALL implement FSM states OCIOSO, ACESSO and ESPERA.
REQ-010 In OCIOSO with at least one req high, SHALL latch the winner, addr, we and wdata, then go to ACESSO; with no req high, SHALL remain in OCIOSO.
REQ-011 SHALL use fixed priority uart > dados > if, subject to REQ-024.
REQ-012 SHALL assert the winner's gnt for exactly one cycle, on the first ACESSO cycle.
- Requesters hold req/addr/wdata until gnt.
REQ-013 SHALL drive mem_en=1 and mem_addr/mem_wdata from the latched values throughout ACESSO and ESPERA.
- mem_we = latched we; if is always read.
- All mem_* outputs are 0 in OCIOSO.
REQ-014 In ACESSO or ESPERA with mem_ready=1, SHALL register mem_rdata into the owner's rdata (reads only), pulse the owner's valid for one cycle next, and return to OCIOSO.
REQ-015 In ACESSO with mem_ready=0, SHALL go to ESPERA; in ESPERA with mem_ready=0, SHALL stay in ESPERA.
REQ-016 Minimum latency SHALL be: req at cycle N -> gnt and mem_en at N+1 -> valid at N+2 (mem_ready at N+1), with the next grant at N+3 at the earliest.
REQ-017 Writes SHALL pulse valid as an acknowledge and leave rdata unchanged; rdata SHALL hold the last read value otherwise.
REQ-018 A latched transaction SHALL complete even if its req drops after capture.
REQ-019 Requests arriving during ACESSO/ESPERA SHALL wait; at most one transaction SHALL be in flight.
REQ-020 SHALL keep an 8-bit wait counter, cleared on entry to ACESSO and incremented each cycle without mem_ready.
- When TIMEOUT != 0 and the counter reaches TIMEOUT: SHALL end the transaction, pulse valid with rdata = 0, set erro, and go to OCIOSO.
REQ-021 stall SHALL be (if_req & ~if_valid) | (dados_req & ~dados_valid), and SHALL be 1 whenever uart owns or is requesting the port.
REQ-022 erro SHALL remain 1 until reset.

Reset
REQ-023 reset=1 SHALL immediately force OCIOSO and zero every output, rdata register, latched field, counter and erro; any in-flight transaction SHALL be dropped with no valid.

Configuration
REQ-024 With macro ARBITRO_ROUND_ROBIN_EN defined, SHALL alternate between dados and if when both are pending (last-served flag, reset to if, so dados wins first); uart stays highest. Without the macro, SHALL use fixed priority dados > if.

Verification
REQ-025 SHALL cover: if_req, if_addr=0x40, mem_ready=1 constant, mem_rdata=0x20090005 -> if_gnt at N+1, if_valid and if_rdata=0x20090005 at N+2.
REQ-026 SHALL cover: dados_req and if_req together, fixed priority -> dados granted first, if granted at N+3; with ARBITRO_ROUND_ROBIN_EN and both held -> grants alternate dados, if, dados.
REQ-027 SHALL cover: dados_we=1, addr 0x100, wdata 0xDEADBEEF, mem_ready delayed 3 cycles -> mem_we=1 for 4 cycles, dados_valid one cycle, dados_rdata unchanged.
REQ-028 SHALL cover: TIMEOUT=4 with mem_ready stuck at 0 -> abort after 4 wait cycles, valid with rdata=0, erro=1 and sticky.
REQ-029 SHALL cover: reset asserted in ESPERA -> outputs 0 that cycle, no valid, next req served normally.

Source files
------------

// File: rtl/arbitro_memoria.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : arbitro_memoria                                                  |
// | Brief   : Three-way arbiter (uart, dados, if) onto one shared memory port, |
// |           with wait timeout and sticky error flag. Optional macro          |
// |           ARBITRO_ROUND_ROBIN_EN alternates dados/if when both pending.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module arbitro_memoria #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dados_req,
    input  logic        dados_we,
    input  logic [31:0] dados_addr,
    input  logic [31:0] dados_wdata,
    output logic        dados_gnt,
    output logic        dados_valid,
    output logic [31:0] dados_rdata,
    input  logic        uart_req,
    input  logic        uart_we,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    output logic        uart_gnt,
    output logic        uart_valid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic        erro
);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ACESSO = 2'd1,
        ESPERA = 2'd2
    } estado_t;

    typedef enum logic [1:0] {
        DONO_IF    = 2'd0,
        DONO_DADOS = 2'd1,
        DONO_UART  = 2'd2
    } dono_t;

    localparam logic [7:0] C_TIMEOUT    = 8'(TIMEOUT);
    localparam logic       C_TIMEOUT_EN = (TIMEOUT != 0);

    estado_t     r_estado;
    dono_t       r_dono;
    logic [7:0]  r_espera;
`ifdef ARBITRO_ROUND_ROBIN_EN
    logic        r_ultimo_dados;
`endif

    dono_t       w_dono;
    logic        w_algum;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_timeout;

    assign w_algum   = uart_req | dados_req | if_req;
    assign w_timeout = C_TIMEOUT_EN && ((r_espera + 8'd1) == C_TIMEOUT);

    always_comb begin
        w_dono = DONO_IF;
        if (uart_req) begin
            w_dono = DONO_UART;
        end else if (dados_req && if_req) begin
`ifdef ARBITRO_ROUND_ROBIN_EN
            w_dono = r_ultimo_dados ? DONO_IF : DONO_DADOS;
`else
            w_dono = DONO_DADOS;
`endif
        end else if (dados_req) begin
            w_dono = DONO_DADOS;
        end
    end

    // Instruction fetch never writes, so its we/wdata are forced to zero.
    always_comb begin
        w_we    = 1'b0;
        w_addr  = if_addr;
        w_wdata = 32'd0;
        case (w_dono)
            DONO_UART: begin
                w_we    = uart_we;
                w_addr  = uart_addr;
                w_wdata = uart_wdata;
            end
            DONO_DADOS: begin
                w_we    = dados_we;
                w_addr  = dados_addr;
                w_wdata = dados_wdata;
            end
            default: ;
        endcase
    end

    assign stall = ~reset & ((if_req & ~if_valid) | (dados_req & ~dados_valid) | uart_req |
                             ((r_estado != OCIOSO) && (r_dono == DONO_UART)));

    // mem_we/mem_addr/mem_wdata double as the latched transaction fields.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado    <= OCIOSO;
            r_dono      <= DONO_IF;
            r_espera    <= 8'd0;
`ifdef ARBITRO_ROUND_ROBIN_EN
            r_ultimo_dados <= 1'b0;
`endif
            if_gnt      <= 1'b0;
            if_valid    <= 1'b0;
            if_rdata    <= 32'd0;
            dados_gnt   <= 1'b0;
            dados_valid <= 1'b0;
            dados_rdata <= 32'd0;
            uart_gnt    <= 1'b0;
            uart_valid  <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            erro        <= 1'b0;
        end else begin
            if_gnt      <= 1'b0;
            dados_gnt   <= 1'b0;
            uart_gnt    <= 1'b0;
            if_valid    <= 1'b0;
            dados_valid <= 1'b0;
            uart_valid  <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (w_algum) begin
                        r_estado  <= ACESSO;
                        r_dono    <= w_dono;
                        r_espera  <= 8'd0;
                        mem_en    <= 1'b1;
                        mem_we    <= w_we;
                        mem_addr  <= w_addr;
                        mem_wdata <= w_wdata;
                        if_gnt    <= (w_dono == DONO_IF);
                        dados_gnt <= (w_dono == DONO_DADOS);
                        uart_gnt  <= (w_dono == DONO_UART);
`ifdef ARBITRO_ROUND_ROBIN_EN
                        if (w_dono != DONO_UART) begin
                            r_ultimo_dados <= (w_dono == DONO_DADOS);
                        end
`endif
                    end
                end
                ACESSO, ESPERA: begin
                    if (mem_ready || w_timeout) begin
                        r_estado  <= OCIOSO;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_wdata <= 32'd0;
                        if (!mem_ready) begin
                            erro <= 1'b1;
                        end
                        case (r_dono)
                            DONO_IF: begin
                                if_valid <= 1'b1;
                                if_rdata <= mem_ready ? mem_rdata : 32'd0;
                            end
                            DONO_DADOS: begin
                                dados_valid <= 1'b1;
                                if (!mem_ready) begin
                                    dados_rdata <= 32'd0;
                                end else if (!mem_we) begin
                                    dados_rdata <= mem_rdata;
                                end
                            end
                            default: uart_valid <= 1'b1;
                        endcase
                    end else begin
                        r_estado <= ESPERA;
                        r_espera <= r_espera + 8'd1;
                    end
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_memoria.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_arbitro_memoria                                               |
// | Brief   : Self-checking bench for arbitro_memoria against a transaction-   |
// |           level memory/arbitration model.                                  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_arbitro_memoria;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0, dados_req = 1'b0, dados_we = 1'b0;
    logic        uart_req = 1'b0, uart_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = '0, dados_addr = '0, dados_wdata = '0;
    logic [31:0] uart_addr = '0, uart_wdata = '0, mem_rdata = '0;
    logic        if_gnt, if_valid, dados_gnt, dados_valid, uart_gnt, uart_valid;
    logic        mem_en, mem_we, stall, erro;
    logic [31:0] if_rdata, dados_rdata, mem_addr, mem_wdata;

    arbitro_memoria #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_rdata(if_rdata),
        .dados_req(dados_req), .dados_we(dados_we), .dados_addr(dados_addr),
        .dados_wdata(dados_wdata), .dados_gnt(dados_gnt), .dados_valid(dados_valid),
        .dados_rdata(dados_rdata),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr),
        .uart_wdata(uart_wdata), .uart_gnt(uart_gnt), .uart_valid(uart_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .erro(erro)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Requester table: index 0 = if, 1 = dados, 2 = uart.
    int          cnt [3];
    int          dly [3];
    logic        f_we [3];
    logic [31:0] f_addr [3];
    logic [31:0] f_wdata [3];

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_dados_rdata = '0;
    logic        exp_erro = 1'b0;
    logic        rr_last_dados = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_C3C3);
    endfunction

    task automatic drive_inputs();
        if_req      = (cnt[0] > 0);
        if_addr     = f_addr[0];
        dados_req   = (cnt[1] > 0);
        dados_we    = f_we[1];
        dados_addr  = f_addr[1];
        dados_wdata = f_wdata[1];
        uart_req    = (cnt[2] > 0);
        uart_we     = f_we[2];
        uart_addr   = f_addr[2];
        uart_wdata  = f_wdata[2];
    endtask

    task automatic clear_table();
        for (int r = 0; r < 3; r++) begin
            cnt[r] = 0; dly[r] = 0; f_we[r] = 1'b0; f_addr[r] = '0; f_wdata[r] = '0;
        end
    endtask

    // Serve every pending transaction in the table, checking each cycle.
    task automatic run_round();
        int w, a;
        logic we_eff, to;
        logic [31:0] rd, wd;
        drive_inputs();
        while (cnt[0] + cnt[1] + cnt[2] > 0) begin
            if (cnt[2] > 0) w = 2;
            else if (cnt[1] > 0 && cnt[0] > 0) begin
`ifdef ARBITRO_ROUND_ROBIN_EN
                w = rr_last_dados ? 0 : 1;
`else
                w = 1;
`endif
            end else if (cnt[1] > 0) w = 1;
            else w = 0;
`ifdef ARBITRO_ROUND_ROBIN_EN
            if (w != 2) rr_last_dados = (w == 1);
`endif
            we_eff = (w == 0) ? 1'b0 : f_we[w];
            wd     = (w == 0) ? 32'd0 : f_wdata[w];
            rd     = '0;
            tick();
            chk("if_gnt", {31'd0, if_gnt}, {31'd0, w == 0});
            chk("dados_gnt", {31'd0, dados_gnt}, {31'd0, w == 1});
            chk("uart_gnt", {31'd0, uart_gnt}, {31'd0, w == 2});
            cnt[w]--;
            drive_inputs();
            #1;
            a  = (dly[w] < TMO) ? dly[w] + 1 : TMO;
            to = (dly[w] >= TMO);
            for (int i = 0; i < a; i++) begin
                chk("mem_en", {31'd0, mem_en}, 32'd1);
                chk("mem_we", {31'd0, mem_we}, {31'd0, we_eff});
                chk("mem_addr", mem_addr, f_addr[w]);
                chk("mem_wdata", mem_wdata, wd);
                chk("stall_acc", {31'd0, stall},
                    {31'd0, (cnt[0] > 0) || (cnt[1] > 0) || (cnt[2] > 0) || (w == 2)});
                if (i > 0) begin
                    chk("gnt_once", {29'd0, uart_gnt, dados_gnt, if_gnt}, 32'd0);
                end
                mem_ready = (i == dly[w]);
                if (mem_ready && !we_eff) begin
                    rd = mem_read(f_addr[w]);
                    mem_rdata = rd;
                end else begin
                    mem_rdata = $urandom();
                end
                if (mem_ready && we_eff) mem_model[f_addr[w]] = wd;
                tick();
            end
            mem_ready = 1'b0;
            if (to) exp_erro = 1'b1;
            if (w == 0) exp_if_rdata = to ? 32'd0 : rd;
            if (w == 1) begin
                if (to) exp_dados_rdata = 32'd0;
                else if (!we_eff) exp_dados_rdata = rd;
            end
            chk("if_valid", {31'd0, if_valid}, {31'd0, w == 0});
            chk("dados_valid", {31'd0, dados_valid}, {31'd0, w == 1});
            chk("uart_valid", {31'd0, uart_valid}, {31'd0, w == 2});
            chk("if_rdata", if_rdata, exp_if_rdata);
            chk("dados_rdata", dados_rdata, exp_dados_rdata);
            chk("mem_en_idle", {31'd0, mem_en}, 32'd0);
            chk("erro", {31'd0, erro}, {31'd0, exp_erro});
            chk("stall_vld", {31'd0, stall},
                {31'd0, (cnt[0] > 0 && w != 0) || (cnt[1] > 0 && w != 1) || (cnt[2] > 0)});
        end
        tick();
        chk("valid_pulse", {29'd0, uart_valid, dados_valid, if_valid}, 32'd0);
    endtask

    initial begin
        clear_table();
        drive_inputs();
        #1 reset = 1'b1;
        #1;
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_gnt", {29'd0, uart_gnt, dados_gnt, if_gnt}, 32'd0);
        chk("rst_valid", {29'd0, uart_valid, dados_valid, if_valid}, 32'd0);
        chk("rst_rdata", if_rdata | dados_rdata, 32'd0);
        chk("rst_erro", {31'd0, erro}, 32'd0);
        tick(); tick();
        reset = 1'b0;

        // Single fetch with immediate ready.
        mem_model[32'h40] = 32'h2009_0005;
        clear_table(); cnt[0] = 1; f_addr[0] = 32'h40;
        run_round();

        // dados and if together, then dados twice against one if.
        clear_table(); cnt[0] = 1; cnt[1] = 1; f_addr[0] = 32'h44; f_addr[1] = 32'h80;
        run_round();
        clear_table(); cnt[0] = 1; cnt[1] = 2; f_addr[0] = 32'h48; f_addr[1] = 32'h84;
        run_round();

        // Delayed write keeps dados_rdata unchanged.
        clear_table(); cnt[1] = 1; f_we[1] = 1'b1; f_addr[1] = 32'h100;
        f_wdata[1] = 32'hDEAD_BEEF; dly[1] = 3;
        run_round();

        // uart write outranks dados; dados then reads what uart wrote.
        clear_table(); cnt[1] = 1; cnt[2] = 1; f_we[2] = 1'b1;
        f_addr[2] = 32'h200; f_wdata[2] = 32'hCAFE_0123; f_addr[1] = 32'h200; dly[2] = 1;
        run_round();

        // Timeout, then a normal read to show erro stays set.
        clear_table(); cnt[0] = 1; f_addr[0] = 32'h300; dly[0] = TMO + 1;
        run_round();
        clear_table(); cnt[1] = 1; f_addr[1] = 32'h100; dly[1] = 2;
        run_round();

        // Reset while waiting in ESPERA.
        clear_table(); cnt[1] = 1; f_addr[1] = 32'h104;
        drive_inputs();
        tick();
        chk("esp_gnt", {31'd0, dados_gnt}, 32'd1);
        cnt[1] = 0; drive_inputs();
        tick();
        chk("esp_en", {31'd0, mem_en}, 32'd1);
        reset = 1'b1;
        #1;
        chk("esp_rst_en", {31'd0, mem_en}, 32'd0);
        chk("esp_rst_addr", mem_addr, 32'd0);
        chk("esp_rst_rdata", if_rdata | dados_rdata, 32'd0);
        chk("esp_rst_erro", {31'd0, erro}, 32'd0);
        chk("esp_rst_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("esp_rst_valid", {31'd0, dados_valid}, 32'd0);
        reset = 1'b0;
        tick();
        chk("esp_no_valid", {29'd0, uart_valid, dados_valid, if_valid}, 32'd0);
        exp_if_rdata = '0; exp_dados_rdata = '0; exp_erro = 1'b0; rr_last_dados = 1'b0;
        clear_table(); cnt[0] = 1; f_addr[0] = 32'h40;
        run_round();

        // Randomized rounds.
        for (int k = 0; k < 40; k++) begin
            clear_table();
            for (int r = 0; r < 3; r++) begin
                cnt[r]    = int'($urandom_range(0, 2));
                dly[r]    = int'($urandom_range(0, 5));
                f_addr[r] = 32'($urandom_range(0, 7)) << 2;
            end
            if (cnt[0] + cnt[1] + cnt[2] == 0) cnt[0] = 1;
            for (int r = 1; r < 3; r++) begin
                f_we[r]    = 1'($urandom_range(0, 1));
                f_wdata[r] = $urandom();
            end
            run_round();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
